// File: rtl/param_mc_datapath_pkg.sv
// Shared constants for the multi-cycle datapath: opcodes, FSM state codes and seven-segment patterns.
package param_mc_datapath_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_MEM   = 2'd2;
  localparam logic [1:0] ST_WB    = 2'd3;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/param_mc_datapath_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
  import param_mc_datapath_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/param_mc_datapath.sv
// Multi-cycle 8-bit-ISA datapath with handshaked instruction fetch and a two-digit result display.
// FETCH wait for instr | EXEC alu, sw commit, jump | MEM dmem read into mdr | WB rf write, pc+1
module param_mc_datapath
  import param_mc_datapath_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PC_W       = 8,
  parameter int DMEM_DEPTH = 32
) (
  input  logic            _CLK,
  input  logic            RESET,
  input  logic            instr_valid,
  input  logic [7:0]      instruction,
  output logic            instr_ready,
  output logic [PC_W-1:0] PC,
  output logic            busy,
  output logic [6:0]      m,
  output logic [6:0]      l
);

  localparam int AW = $clog2(DMEM_DEPTH);

  logic [1:0]        state;
  logic [7:0]        ir;
  logic [DATA_W-1:0] rf [4];
  logic [DATA_W-1:0] mem [DMEM_DEPTH];
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] last_result;

  logic [1:0]        op;
  logic [1:0]        rs;
  logic [1:0]        rt;
  logic [1:0]        fn;
  logic [DATA_W-1:0] f_sext;
  logic [DATA_W-1:0] sum;
  logic [AW-1:0]     addr;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   j_target;
  logic [6:0]        seg_hi;
  logic [6:0]        seg_lo;

  assign op = ir[7:6];
  assign rs = ir[5:4];
  assign rt = ir[3:2];
  assign fn = ir[1:0];

  // IR and the register file are stable from EXEC through WB, so decode stays combinational
  assign f_sext   = DATA_W'($signed(fn));
  assign sum      = rf[rs] + rf[rt];
  assign addr     = AW'(rf[rs] + f_sext);
  assign pc_inc   = PC + PC_W'(1);
  assign j_target = pc_inc + PC_W'($signed(ir[5:0]));

  assign instr_ready = (state == ST_FETCH);
  assign busy        = (state != ST_FETCH);

  always_ff @(posedge _CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_FETCH;
      PC          <= '0;
      ir          <= '0;
      alu_out     <= '0;
      mdr         <= '0;
      last_result <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= DATA_W'(i);
      for (int k = 0; k < DMEM_DEPTH; k++) mem[k] <= DATA_W'(k);
    end else begin
      case (state)
        ST_FETCH: begin
          if (instr_valid) begin
            ir    <= instruction;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op)
            OP_ADD: begin
              alu_out <= sum;
              state   <= ST_WB;
            end
            OP_LW: state <= ST_MEM;
            OP_SW: begin
              mem[addr]   <= rf[rt];
              last_result <= rf[rt];
              PC          <= pc_inc;
              state       <= ST_FETCH;
            end
            default: begin
              PC    <= j_target;
              state <= ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          mdr   <= mem[addr];
          state <= ST_WB;
        end
        default: begin
          if (op == OP_ADD) begin
            rf[fn]      <= alu_out;
            last_result <= alu_out;
          end else begin
            rf[rt]      <= mdr;
            last_result <= mdr;
          end
          PC    <= pc_inc;
          state <= ST_FETCH;
        end
      endcase
    end
  end

  hex_to_seg7 u_seg_hi (.hex(last_result[7:4]), .seg(seg_hi));
  hex_to_seg7 u_seg_lo (.hex(last_result[3:0]), .seg(seg_lo));

  // Display is registered so the digits never see decoder glitches
  always_ff @(posedge _CLK or posedge RESET) begin
    if (RESET) begin
      m <= SEG_0;
      l <= SEG_0;
    end else begin
      m <= seg_hi;
      l <= seg_lo;
    end
  end

endmodule

// File: tb/tb_param_mc_datapath.sv
// Directed and random checks of param_mc_datapath against an architectural reference model.
module tb_param_mc_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       instr_valid = 1'b0;
  logic [7:0] instruction = 8'h00;
  logic       instr_ready;
  logic [7:0] pc_o;
  logic       busy;
  logic [6:0] m;
  logic [6:0] l;

  int vectors = 0;
  int miscompares = 0;

  int r [4];
  int mem [32];
  int pc;
  int last;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  param_mc_datapath #(.DATA_W(8), .PC_W(8), .DMEM_DEPTH(32)) dut (
    ._CLK(clk),
    .RESET(rst),
    .instr_valid(instr_valid),
    .instruction(instruction),
    .instr_ready(instr_ready),
    .PC(pc_o),
    .busy(busy),
    .m(m),
    .l(l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) r[i] = i;
    for (int k = 0; k < 32; k++) mem[k] = k;
    pc = 0;
    last = 0;
  endtask

  task automatic check_display(input string tag);
    check({tag, "_m"}, 32'(m), 32'(seg_tab[(last >> 4) & 15]));
    check({tag, "_l"}, 32'(l), 32'(seg_tab[last & 15]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_pc", 32'(pc_o), 0);
    check("rst_ready", 32'(instr_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic exec_instr(input logic [7:0] ins);
    int op, rs, rt, f, sf, soff, addr, lat, edges;
    op = ins[7:6]; rs = ins[5:4]; rt = ins[3:2]; f = ins[1:0];
    sf = (f >= 2) ? f - 4 : f;
    soff = (ins[5:0] >= 32) ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
    addr = (((r[rs] + sf) % 32) + 32) % 32;
    case (op)
      0: begin r[f] = (r[rs] + r[rt]) % 256; last = r[f]; pc = (pc + 1) % 256; lat = 3; end
      1: begin r[rt] = mem[addr]; last = r[rt]; pc = (pc + 1) % 256; lat = 4; end
      2: begin mem[addr] = r[rt]; last = r[rt]; pc = (pc + 1) % 256; lat = 2; end
      default: begin pc = (pc + 1 + soff + 256) % 256; lat = 2; end
    endcase
    @(negedge clk);
    check("ready_fetch", 32'(instr_ready), 1);
    instruction = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 1);
    // junk on the fetch port while busy must be ignored
    while (busy === 1'b1 && edges < 12) begin
      instruction = 8'($urandom);
      instr_valid = 1'($urandom);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("latency", 32'(edges), 32'(lat));
    check("pc", 32'(pc_o), 32'(pc));
    @(negedge clk);
    check_display("disp");
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(instr_ready), 1);
      check("idle_busy", 32'(busy), 0);
      check("idle_pc", 32'(pc_o), 0);
      check("idle_m", 32'(m), 32'(7'b1000000));
      check("idle_l", 32'(l), 32'(7'b1000000));
    end

    exec_instr(8'b00011011);
    check("add_l", 32'(l), 32'(7'b0110000));
    check("add_m", 32'(m), 32'(7'b1000000));
    check("add_pc", 32'(pc_o), 1);
    exec_instr(8'b01110001);
    check("lw_l", 32'(l), 32'(7'b0011001));
    check("lw_pc", 32'(pc_o), 2);
    exec_instr(8'b10011011);
    check("sw_pc", 32'(pc_o), 3);
    exec_instr(8'b01000101);
    check("lw_r1_l", 32'(l), 32'(7'b0010010));
    exec_instr(8'b01101110);
    check("lw_mem0_l", 32'(l), 32'(7'b0100100));

    do_reset();
    exec_instr(8'b11111110);
    check("j_wrap_down", 32'(pc_o), 32'h0FF);
    exec_instr(8'b11000001);
    check("j_wrap_up", 32'(pc_o), 1);

    do_reset();
    exec_instr(8'b00000000);
    @(negedge clk);
    instruction = 8'b01110100;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mem_state_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("abort_pc", 32'(pc_o), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_ready", 32'(instr_ready), 1);
    check("abort_l", 32'(l), 32'(7'b1000000));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("post_rst_ready", 32'(instr_ready), 1);
    exec_instr(8'b00010000);
    check("abort_r1_kept", 32'(l), 32'(7'b1111001));

    do_reset();
    repeat (60) exec_instr(8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_mc_datapath.md
Name: param_mc_datapath

Overview:
- Next-generation 8-bit-ISA processor datapath: multi-cycle FSM replaces the single-cycle core.
- Parametrised data width, PC width and data-memory depth.
- Instruction fetch uses a valid/ready handshake with the external instruction source.
- Drives two active-low seven-segment digits showing the most recent write result.

Parameters:
DATA_W, 8, register/memory word width (>=8)
PC_W, 8, program counter width (>=6)
DMEM_DEPTH, 32, data memory words (power of 2, >=4)

Ports:
_CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction word present on instruction
instruction  in  8  {op[7:6], rs[5:4], rt[3:2], f[1:0]}
instr_ready  out  1  core accepts an instruction this cycle
PC  out  PC_W  address of the instruction being fetched/executed
busy  out  1  high in every state except FETCH
m  out  7  seg code of bits [7:4] of last result, active-low, {g,f,e,d,c,b,a}
l  out  7  seg code of bits [3:0] of last result, same encoding

Behaviour:
- Interface: one clock _CLK; RESET is asynchronous and active-high.
- Reset (async assert, takes effect immediately):
  - PC=0, state=FETCH, IR=0, last result=0 (m=l=7'b1000000).
  - Register file r[i]=i for i=0..3.
  - Data memory mem[k]=k for all k.
- ISA:
  - op 00 add: r[f] = r[rs]+r[rt], modulo 2^DATA_W.
  - op 01 lw: r[rt] = mem[addr].
  - op 10 sw: mem[addr] = r[rt].
  - op 11 j: PC = PC+1+sext(instruction[5:0]), modulo 2^PC_W.
  - addr = (r[rs]+sext(f)) mod DMEM_DEPTH, where f is sign-extended 2-bit.
  - All four registers are writable; none is hardwired to zero.
- FSM states: FETCH, EXEC, MEM, WB.
  - FETCH: instr_ready=1. On instr_valid=1, latch IR and go to EXEC. Otherwise stay; PC stable.
  - EXEC: ALU computes sum/addr.
    - add -> WB.
    - lw -> MEM.
    - sw -> write mem, PC+=1, last result=r[rt], -> FETCH.
    - j -> load PC -> FETCH.
  - MEM: synchronous memory read into MDR -> WB.
  - WB: write rf, last result=written value, PC+=1 -> FETCH.
- Latency, from the accept edge to the next FETCH: add 3 cycles, lw 4, sw 2, j 2.
- Rules:
  - instruction and instr_valid are ignored outside FETCH.
  - PC wraps modulo 2^PC_W in both directions.
  - m and l are registered from last result: no glitches, updated the cycle after the write.
  - Only bits [7:0] of last result are displayed.
- Reset mid-operation aborts the instruction. Pending rf/mem writes are discarded, except a sw already committed on the EXEC edge.

Decomposition:
- Shared package: opcode constants (OP_ADD, OP_LW, OP_SW, OP_J), FSM state encodings, seg7 code constants for 0-F.
- One sub-module: hex_to_seg7 (4-bit in, 7-bit active-low out, combinational), instantiated twice for m and l.
- Register file, data memory and FSM stay inline.

Test Plan (DATA_W=8, PC_W=8, DMEM_DEPTH=32):
1. Hold instr_valid=0 for 5 cycles after reset -> instr_ready=1, busy=0, PC=0 throughout, m=l=7'b1000000.
2. Present 8'b00011011 (add r3=r1+r2) -> r3=3; PC=1 exactly 3 cycles after accept; l=7'b0110000, m=7'b1000000. Change instruction during EXEC -> no effect.
3. Then 8'b01110001 (lw r0=mem[r3+1]) -> r0=4, l=7'b0011001, PC=2 after 4 cycles.
4. 8'b10011011 (sw mem[r1-1]=r2) -> mem[0]=2, PC+1 after 2 cycles. Follow with 8'b01000101 (lw r1=mem[r0+1]) -> r1=5.
5. From PC=0, 8'b11111110 (j -2) -> PC=8'hFF. 8'b11000001 at PC=8'hFF -> PC=1 (wrap up).
6. Assert RESET in the MEM cycle of a lw -> immediately PC=0, state FETCH, target register keeps its reset value, instr_ready=1 on the first post-reset edge.
